// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 request-port arbiter (lc3b line/word types, owner and state enums).
// Build option: define ARB_RR_EN for round-robin arbitration instead of D priority with starvation limit.
package l2_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    I    = 2'd1,
    D    = 2'd2
  } arb_owner_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/l2_arbiter_select.sv
// Combinational winner choice between the I and D miss requests.
// ARB_RR_EN selects round-robin on ties; otherwise D wins unless I has hit the starvation limit.
module l2_arbiter_select
  import l2_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
`ifdef ARB_RR_EN
  input  logic                    last_was_d,
`else
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
`endif
  input  logic                    icache_req,
  input  logic                    dcache_req,
  output logic                    grant_i,
  output logic                    grant_d
);

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
`ifdef ARB_RR_EN
    if (icache_req && dcache_req) begin
      grant_d = !last_was_d;
      grant_i = last_was_d;
    end else begin
      grant_i = icache_req;
      grant_d = dcache_req;
    end
`else
    if (dcache_req && !(icache_req && (starve_cnt == STARVE_CNT_W'(STARVE_LIMIT)))) begin
      grant_d = 1'b1;
    end else if (icache_req) begin
      grant_i = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the unified L2 request port between the L1 I-cache and D-cache; the granted request is registered.
// Build option: ARB_RR_EN (round-robin ties); default is D priority with a STARVE_LIMIT guarantee for I.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       icache_read,
  input  lc3b_word   icache_address,
  output logic       icache_resp,
  output lc3b_c_line icache_rdata,
  input  logic       dcache_read,
  input  logic       dcache_write,
  input  lc3b_word   dcache_address,
  input  lc3b_c_line dcache_wdata,
  output logic       dcache_resp,
  output lc3b_c_line dcache_rdata,
  output logic       l2_read,
  output logic       l2_write,
  output lc3b_word   l2_address,
  output lc3b_c_line l2_wdata,
  input  logic       l2_resp,
  input  lc3b_c_line l2_rdata,
  output arb_owner_t arb_owner
);

  // Handshake: each L1 holds read/write asserted until its resp pulse; the L2 side holds
  // l2_read/l2_write and the registered address/data stable until l2_resp.
  arb_state_t state, state_nxt;
  logic       l2_read_nxt, l2_write_nxt;
  lc3b_word   l2_address_nxt;
  lc3b_c_line l2_wdata_nxt;
  logic       grant_i, grant_d;
  logic       dcache_req;

  assign dcache_req = dcache_read || dcache_write;

`ifdef ARB_RR_EN
  logic last_was_d, last_was_d_nxt;

  l2_arbiter_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .last_was_d (last_was_d),
    .icache_req (icache_read),
    .dcache_req (dcache_req),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  always_comb begin
    last_was_d_nxt = last_was_d;
    if (state == IDLE && grant_d) last_was_d_nxt = 1'b1;
    else if (state == IDLE && grant_i) last_was_d_nxt = 1'b0;
  end

  // Resetting to "last was I" lets D take the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_was_d <= 1'b0;
    else        last_was_d <= last_was_d_nxt;
  end
`else
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_cnt_nxt;

  l2_arbiter_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_select (
    .starve_cnt (starve_cnt),
    .icache_req (icache_read),
    .dcache_req (dcache_req),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Counts D grants that I sat through; saturates so the limit compare stays exact.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (state == IDLE && grant_i) begin
      starve_cnt_nxt = '0;
    end else if (state == IDLE && grant_d) begin
      if (!icache_read)                                     starve_cnt_nxt = '0;
      else if (starve_cnt != STARVE_CNT_W'(STARVE_LIMIT))   starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_nxt;
  end
`endif

  always_comb begin
    state_nxt      = state;
    l2_read_nxt    = l2_read;
    l2_write_nxt   = l2_write;
    l2_address_nxt = l2_address;
    l2_wdata_nxt   = l2_wdata;
    case (state)
      IDLE: begin
        if (grant_d) begin
          // A simultaneous read+write is treated as the write-back.
          state_nxt      = GRANT_D;
          l2_write_nxt   = dcache_write;
          l2_read_nxt    = !dcache_write;
          l2_address_nxt = dcache_address;
          l2_wdata_nxt   = dcache_wdata;
        end else if (grant_i) begin
          state_nxt      = GRANT_I;
          l2_read_nxt    = 1'b1;
          l2_write_nxt   = 1'b0;
          l2_address_nxt = icache_address;
          l2_wdata_nxt   = '0;
        end
      end
      GRANT_I, GRANT_D: begin
        if (l2_resp) begin
          state_nxt    = IDLE;
          l2_read_nxt  = 1'b0;
          l2_write_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        l2_read_nxt  = 1'b0;
        l2_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
    end else begin
      state      <= state_nxt;
      l2_read    <= l2_read_nxt;
      l2_write   <= l2_write_nxt;
      l2_address <= l2_address_nxt;
      l2_wdata   <= l2_wdata_nxt;
    end
  end

  assign icache_resp  = (state == GRANT_I) && l2_resp;
  assign dcache_resp  = (state == GRANT_D) && l2_resp;
  assign icache_rdata = l2_rdata;
  assign dcache_rdata = l2_rdata;

  // arb_owner mirrors the FSM state one-to-one and doubles as its debug view.
  always_comb begin
    arb_owner = NONE;
    case (state)
      GRANT_I: arb_owner = I;
      GRANT_D: arb_owner = D;
      default: arb_owner = NONE;
    endcase
  end

`ifndef SYNTHESIS
  d_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(dcache_read && dcache_write));
`endif

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Shares the single unified L2 cache request port between the L1 instruction cache and the L1 data cache.
- Sits between both L1 miss interfaces and the L2 cache memory-side port (mem_read/mem_write/mem_address/mem_wdata/mem_resp/mem_rdata).
- Grants one requester at a time and registers the granted request so the L2 sees stable inputs.
- Routes mem_resp and mem_rdata back to the owner only.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive D grants while I is pending before I is forced; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_read  in  1  I-side line read request; held until icache_resp.
- icache_address  in  lc3b_word  I-side line address.
- icache_resp  out  1  I-side completion pulse.
- icache_rdata  out  lc3b_c_line  I-side read line.
- dcache_read  in  1  D-side read request; held until dcache_resp.
- dcache_write  in  1  D-side write-back request; held until dcache_resp.
- dcache_address  in  lc3b_word  D-side line address.
- dcache_wdata  in  lc3b_c_line  D-side write line.
- dcache_resp  out  1  D-side completion pulse.
- dcache_rdata  out  lc3b_c_line  D-side read line.
- l2_read  out  1  to L2 mem_read.
- l2_write  out  1  to L2 mem_write.
- l2_address  out  lc3b_word  to L2 mem_address.
- l2_wdata  out  lc3b_c_line  to L2 mem_wdata.
- l2_resp  in  1  from L2 mem_resp.
- l2_rdata  in  lc3b_c_line  from L2 mem_rdata.
- arb_owner  out  2  current grant, arb_owner_t: NONE=0, I=1, D=2.

Behaviour:
- Reset (rst_n low, any time, including mid-transaction):
  - State to IDLE and starve_cnt to 0.
  - l2_read, l2_write, icache_resp, dcache_resp all 0.
  - l2_address and l2_wdata 0; arb_owner NONE.
  - A transaction aborted by reset is not replayed; the L1s restart their own FSMs on the same reset.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - With no request, stay in IDLE.
  - With a request pending in cycle N, select per the priority rule below.
  - Latch address, wdata and read/write of the winner into output registers.
  - Enter GRANT_x at edge N+1; l2_read or l2_write is high from cycle N+1.
- GRANT_x:
  - Registered L2 request outputs stay constant until l2_resp.
  - Forward l2_resp combinationally to the owner's resp in the same cycle; the non-owner's resp is always 0.
  - icache_rdata and dcache_rdata both carry l2_rdata unconditionally; only resp qualifies them.
  - On l2_resp, clear l2_read and l2_write and return to IDLE at the next edge. The minimum IDLE dwell is 1 cycle, so a requester that drops its request after resp is never double-served.
- Priority (default, fixed D-over-I with anti-starvation):
  - D wins if dcache_read or dcache_write is asserted, unless icache_read is asserted and starve_cnt == STARVE_LIMIT, in which case I wins.
  - starve_cnt increments on each D grant while icache_read is high, saturating at STARVE_LIMIT.
  - starve_cnt clears on any I grant, or on a D grant when icache_read is low.
- Simultaneous dcache_read and dcache_write is illegal:
  - Treat it as a write.
  - Simulation-only assertion fires.
- A request that changes address while held is a protocol violation. The latched value is used.
- Requests arriving during GRANT_x wait; no queueing beyond the held-request convention.
- Latency: uncontended request-to-resp = 1 + L2 latency cycles.

Optional Feature:
- Macro ARB_RR_EN.
- Defined:
  - Strict round-robin: when both are pending in IDLE, grant the side not granted last.
  - A last_owner flop resets to I, so D wins the first tie.
  - starve_cnt and STARVE_LIMIT are unused and removed.
- Undefined: fixed D priority with starvation limit as above.

Decomposition:
- Add to lc3b_types: arb_owner_t enum (NONE, I, D).
- Reuse lc3b_word and lc3b_c_line.
- One natural sub-module: l2_arbiter_select.
  - Combinational winner choice from requests, starve_cnt or last_owner, and STARVE_LIMIT.
  - Keeps the FSM/register file in l2_arbiter.

Test Plan:
1. I-only: icache_read=1, addr 0x1230, L2 resp after 3 cycles.
   - l2_read=1 from cycle+1 with l2_address=0x1230.
   - icache_resp=1 exactly when l2_resp=1; dcache_resp stays 0.
2. Tie, default build: icache_read and dcache_read both at 0x0040/0x8000.
   - D granted first (l2_address=0x8000); I granted after D's resp plus 1 IDLE cycle.
3. Starvation, STARVE_LIMIT=4: D requests back-to-back with I held high.
   - Exactly 4 D grants, then I granted; starve_cnt=0 afterwards.
4. Write-back: dcache_write=1, wdata=128'hDEAD…BEEF, addr 0x2450.
   - l2_write=1 with l2_wdata and l2_address held stable until l2_resp; dcache_resp 1 cycle.
5. Reset mid-GRANT_D: drop rst_n asynchronously while l2_write=1.
   - All outputs 0 immediately; after release, IDLE with arb_owner=NONE.
6. ARB_RR_EN build: both sides requesting continuously.
   - Grants alternate D, I, D, I; arb_owner sequence 2,0,1,0,2.
